barrett_reduce: RTL and testbench
=================================

// Module: barrett_reduce
// PURPOSE
//  Pipelined signed Barrett reduction of a 16-bit coefficient modulo Q=3329 (Kyber).
//  Returns a centred representative congruent to the input mod Q.
//  Sits after the NTT butterfly/pointwise multipliers in the NTT datapath; accepts one input per cycle.
// PARAMETERS
//  WIDTH  16  coefficient width (signed two's complement), input and output
//  Q      3329  modulus
//  SHIFT  26  Barrett shift; constant V = ((1<<SHIFT)+Q/2)/Q = 20159 (localparam, derived)
// PORTS
//  clk        in   1      rising-edge clock, single clock domain
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      input sample valid this cycle
//  a          in   WIDTH  signed input coefficient
//  out_valid  out  1      result valid this cycle
//  result     out  WIDTH  signed reduced coefficient
// BEHAVIOUR
//  - Arithmetic (bit-exact to Kyber reference): p = V*a (32b signed);
//    t = (p + (1<<(SHIFT-1))) >>> SHIFT (arithmetic shift = floor); result = a - t*Q.
//  - Intermediate widths: p, p+rounding in 32b signed; t fits 5b signed (-10..10); t*Q in 17b signed;
//    final difference truncated to WIDTH (always in range).
//  - Output range over full input range [-32768,32767]: result in [-1664,1664], result == a (mod Q).
//  - Pipeline: stage 1 registers a and p; stage 2 registers result. Latency 2 cycles; throughput 1/cycle.
//  - in_valid delayed through a matching 2-bit shift register to form out_valid.
//  - No backpressure; every valid input produces exactly one output 2 cycles later, in order.
//  - Data registers update unconditionally (no enable gating); result is don't-care when out_valid=0.
//  - Reset (async assert, sync-safe release): out_valid=0, result=0, all pipeline registers 0.
//  - Reset mid-operation: in-flight samples discarded; first post-reset output is 2 cycles after next in_valid.
//  - Back-to-back and bubbled inputs both supported; bubbles propagate as out_valid=0.
// CONFIGURATION
//  BARRETT_REDUCE_CANON_EN:
//   defined     -> stage 2 adds Q when the centred result is negative; result in [0,Q-1]; latency unchanged.
//   not defined -> centred signed result as above.
// STRUCTURE
//  - Shared package kyber_pkg: KYBER_Q=3329, BARRETT_SHIFT=26, BARRETT_V=20159,
//    typedef logic signed [15:0] coeff_t.
//  - One combinational sub-module barrett_quot: a -> t (multiply, round, shift).
//    Used by stage 1 (multiply) and stage 2 (shift/subtract), or split as implementer prefers
//    while keeping the 2-cycle latency.
// TESTING
//  1. Hold rst=1 with in_valid=1 -> out_valid=0, result=0; deassert -> first out_valid exactly 2 cycles after first in_valid.
//  2. a=0 -> 0; a=1000 -> 1000; a=-1000 -> -1000 (CANON_EN: 0, 1000, 2329).
//  3. a=5423 -> -1235; a=-2000 -> 1329 (CANON_EN: 2094, 1329).
//  4. Extremes: a=32767 -> -523; a=-32768 -> 522; a=3329 -> 0; a=1664 -> 1664; a=1665 -> -1664.
//  5. Streaming: 1000 random inputs, in_valid randomly toggled -> outputs in order, 2-cycle latency,
//     each matches the software model and is congruent mod Q.
//  6. Assert rst with 2 samples in flight -> out_valid stays 0, no stale sample emitted after release.

Source files
------------

// File: rtl/kyber_pkg.sv
// Shared Kyber constants and coefficient type.
// Used by the Barrett reduction datapath.
package kyber_pkg;

   localparam int KYBER_Q       = 3329;
   localparam int BARRETT_SHIFT = 26;
   localparam int BARRETT_V     =
      ((1 << BARRETT_SHIFT) + KYBER_Q / 2) / KYBER_Q;

   typedef logic signed [15:0] coeff_t;

endpackage

// File: rtl/barrett_quot.sv
// Barrett quotient: multiply by V, then round and arithmetic shift.
// The multiply and shift halves are split so a register can sit between them.
module barrett_quot
   import kyber_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int Q     = KYBER_Q,
   parameter int SHIFT = BARRETT_SHIFT
) (
   input  logic signed [WIDTH-1:0]   a,
   output logic signed [2*WIDTH-1:0] p,
   input  logic signed [2*WIDTH-1:0] p_r,
   output logic signed [2*WIDTH-1:0] t
);

   localparam int PW = 2 * WIDTH;
   localparam int V  = ((1 << SHIFT) + Q / 2) / Q;

   localparam logic signed [PW-1:0] VS  = PW'(V);
   localparam logic signed [PW-1:0] RND = PW'(1) << (SHIFT - 1);

   logic signed [PW-1:0] a_ext;

   assign a_ext = PW'(a);
   assign p     = VS * a_ext;
   // floor division by 2^SHIFT after adding half: round to nearest
   assign t     = (p_r + RND) >>> SHIFT;

endmodule

// File: rtl/barrett_reduce.sv
// Two-stage signed Barrett reduction mod Q, one sample per cycle.
// Define BARRETT_REDUCE_CANON_EN for a [0,Q-1] result instead of centred.
module barrett_reduce
   import kyber_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int Q     = KYBER_Q,
   parameter int SHIFT = BARRETT_SHIFT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic signed [WIDTH-1:0] a,
   output logic                    out_valid,
   output logic signed [WIDTH-1:0] result
);

   localparam int PW = 2 * WIDTH;

   localparam logic signed [PW-1:0]    QP = PW'(Q);
   localparam logic signed [WIDTH-1:0] QW = WIDTH'(Q);

   logic        [1:0]       vld;
   logic signed [WIDTH-1:0] a_r;
   logic signed [PW-1:0]    p;
   logic signed [PW-1:0]    p_r;
   logic signed [PW-1:0]    t;
   logic signed [PW-1:0]    diff;
   logic signed [WIDTH-1:0] cen;
   logic signed [WIDTH-1:0] res_d;

   barrett_quot #(
      .WIDTH(WIDTH),
      .Q    (Q),
      .SHIFT(SHIFT)
   ) u_quot (
      .a  (a),
      .p  (p),
      .p_r(p_r),
      .t  (t)
   );

   assign diff = PW'(a_r) - t * QP;
   assign cen  = diff[WIDTH-1:0];

`ifdef BARRETT_REDUCE_CANON_EN
   assign res_d = cen[WIDTH-1] ? cen + QW : cen;
`else
   assign res_d = cen;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld    <= '0;
         a_r    <= '0;
         p_r    <= '0;
         result <= '0;
      end else begin
         vld    <= {vld[0], in_valid};
         a_r    <= a;
         p_r    <= p;
         result <= res_d;
      end
   end

   assign out_valid = vld[1];

endmodule

// File: tb/tb_barrett_reduce.sv
// Scoreboard bench for barrett_reduce: directed, streaming and reset cases.
// Expected values follow BARRETT_REDUCE_CANON_EN when it is defined.
module tb_barrett_reduce;
   import kyber_pkg::*;

   logic   clk = 1'b0;
   logic   rst;
   logic   in_valid;
   coeff_t a;
   logic   out_valid;
   coeff_t result;

   int nchk = 0;
   int nerr = 0;
   int cyc  = 0;

   coeff_t eq[$];
   coeff_t aq[$];
   int     cq[$];

   barrett_reduce dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .a        (a),
      .out_valid(out_valid),
      .result   (result)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // independent reference: true remainder, then centre it
   function automatic coeff_t ref_red(input int x);
      int r;
      r = x % 3329;
      if (r < 0) r += 3329;
`ifndef BARRETT_REDUCE_CANON_EN
      if (r > 1664) r -= 3329;
`endif
      return coeff_t'(r);
   endfunction

   task automatic send(input coeff_t v, input coeff_t exp);
      in_valid = 1'b1;
      a        = v;
      eq.push_back(exp);
      aq.push_back(v);
      cq.push_back(cyc);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   coeff_t m_e;
   coeff_t m_a;
   int     m_c;

   always @(negedge clk) begin
      if (rst) begin
         nchk++;
         if (out_valid !== 1'b0 || result !== '0) begin
            nerr++;
            $display("FAIL reset_state: out_valid=%b result=%0d want 0/0",
                     out_valid, result);
         end
      end else if (out_valid === 1'b1) begin
         nchk++;
         if (eq.size() == 0) begin
            nerr++;
            $display("FAIL spurious_out: result=%0d at cycle %0d, none expected",
                     result, cyc);
         end else begin
            m_e = eq.pop_front();
            m_a = aq.pop_front();
            m_c = cq.pop_front();
            if (result !== m_e || cyc != m_c + 2) begin
               nerr++;
               $display("FAIL data a=%0d: got %0d at lat %0d, want %0d at lat 2",
                        m_a, result, cyc - m_c, m_e);
            end
            nchk++;
            if ((int'(m_a) - int'(result)) % 3329 != 0) begin
               nerr++;
               $display("FAIL congruence a=%0d: got %0d, not congruent mod 3329",
                        m_a, result);
            end
         end
      end else if (out_valid !== 1'b0) begin
         nchk++;
         nerr++;
         $display("FAIL out_valid_x: got %b want 0/1", out_valid);
      end
   end

   coeff_t dv[10] = '{
      16'sd0, 16'sd1000, -16'sd1000, 16'sd5423, -16'sd2000,
      16'sd32767, -16'sd32768, 16'sd3329, 16'sd1664, 16'sd1665
   };
`ifdef BARRETT_REDUCE_CANON_EN
   coeff_t de[10] = '{
      16'sd0, 16'sd1000, 16'sd2329, 16'sd2094, 16'sd1329,
      16'sd2806, 16'sd522, 16'sd0, 16'sd1664, 16'sd1665
   };
   coeff_t late_exp = 16'sd3324;
`else
   coeff_t de[10] = '{
      16'sd0, 16'sd1000, -16'sd1000, -16'sd1235, 16'sd1329,
      -16'sd523, 16'sd522, 16'sd0, 16'sd1664, -16'sd1664
   };
   coeff_t late_exp = -16'sd5;
`endif

   initial begin
      int sent;
      coeff_t v;
      rst      = 1'b1;
      in_valid = 1'b1;
      a        = 16'sd1234;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 10; i++) send(dv[i], de[i]);
      idle(3);
      for (int i = 0; i < 10; i++) begin
         send(dv[i], de[i]);
         idle(1);
      end

      sent = 0;
      while (sent < 1000) begin
         if ($urandom_range(0, 3) == 0) begin
            idle(1);
         end else begin
            v = coeff_t'($urandom);
            send(v, ref_red(int'(v)));
            sent++;
         end
      end
      idle(4);

      send(16'sd100, 16'sd100);
      send(16'sd200, 16'sd200);
      rst = 1'b1;
      eq.delete();
      aq.delete();
      cq.delete();
      idle(3);
      rst = 1'b0;
      idle(4);
      send(-16'sd5, late_exp);

      for (int i = 0; i < 20 && eq.size() > 0; i++) @(posedge clk);
      idle(2);
      nchk++;
      if (eq.size() != 0) begin
         nerr++;
         $display("FAIL drain: %0d outputs outstanding, want 0", eq.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
      $finish;
   end

endmodule
